// File: rtl/cpu_wb_pkg.sv
// Shared definitions for the CPU writeback arbiter.
//   REG_WIDTH / NUM_REGS : datapath width and architectural register count
//   RID_W                : register-id width derived from NUM_REGS
//   wb_entry_t           : what a channel FIFO stores (destination + selected data)
//   wb_req_t             : one channel's raw writeback request as presented on the bus
package cpu_wb_pkg;

    localparam int REG_WIDTH = 32;
    localparam int NUM_REGS  = 32;

    // Register-id width; a single-register file still needs one id bit.
    function automatic int rid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RID_W = rid_w(NUM_REGS);

    typedef struct packed {
        logic [RID_W-1:0]     rd;
        logic [REG_WIDTH-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic                 valid;
        logic                 mem_to_reg;
        logic [RID_W-1:0]     rd;
        logic [REG_WIDTH-1:0] mem_data;
        logic [REG_WIDTH-1:0] alu_data;
    } wb_req_t;

endpackage

// File: rtl/cpu_writeback_arbiter_if.sv
// Bus between writeback sources / register file and the writeback arbiter.
//   ch_*      : per-channel writeback requests (valid/ready handshake)
//   wr_*      : registered register-file write ports
//   pend_mask : registers with a write queued or being presented
// Handshake: a channel transfer happens on a rising clk edge where
// ch_valid[c] and ch_ready[c] are both 1; ch_ready depends only on
// registered state, never on ch_valid.
// master = sources + register file side, slave = arbiter.
interface cpu_writeback_arbiter_if
    import cpu_wb_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int NUM_WR_PORTS = 1
);
    logic [NUM_CH-1:0]                      ch_valid;
    logic [NUM_CH-1:0]                      ch_ready;
    logic [NUM_CH-1:0]                      ch_mem_to_reg;
    logic [NUM_CH-1:0][RID_W-1:0]           ch_rd;
    logic [NUM_CH-1:0][REG_WIDTH-1:0]       ch_mem_data;
    logic [NUM_CH-1:0][REG_WIDTH-1:0]       ch_alu_data;
    logic [NUM_WR_PORTS-1:0]                wr_en;
    logic [NUM_WR_PORTS-1:0][RID_W-1:0]     wr_addr;
    logic [NUM_WR_PORTS-1:0][REG_WIDTH-1:0] wr_data;
    logic [NUM_REGS-1:0]                    pend_mask;

    modport master (
        output ch_valid, ch_mem_to_reg, ch_rd, ch_mem_data, ch_alu_data,
        input  ch_ready, wr_en, wr_addr, wr_data, pend_mask
    );

    modport slave (
        input  ch_valid, ch_mem_to_reg, ch_rd, ch_mem_data, ch_alu_data,
        output ch_ready, wr_en, wr_addr, wr_data, pend_mask
    );
endinterface

// File: rtl/cpu_wb_fifo.sv
// Per-channel writeback FIFO.
//   push/push_entry : enqueue (caller guarantees count < FIFO_DEPTH)
//   pop             : dequeue head (caller guarantees count != 0)
//   head            : oldest entry
//   count           : occupancy, 0..FIFO_DEPTH
//   ent_valid/ents  : flat view of every slot, for pending-register tracking
module cpu_wb_fifo
    import cpu_wb_pkg::*;
#(
    parameter int  FIFO_DEPTH = 2,
    parameter type entry_t    = wb_entry_t
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  entry_t                          push_entry,
    input  logic                            pop,
    output entry_t                          head,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic [FIFO_DEPTH-1:0]           ent_valid,
    output entry_t [FIFO_DEPTH-1:0]         ents
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    entry_t [FIFO_DEPTH-1:0] mem;
    logic   [PTR_W-1:0]      wr_ptr;
    logic   [PTR_W-1:0]      rd_ptr;

    // Storage is not reset: slot contents only matter while ent_valid is set.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign ents = mem;

    // Slot i is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] off;
        off       = '0;
        ent_valid = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off          = PTR_W'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, off} < count);
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> (count != '0));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> (count != (PTR_W+1)'(FIFO_DEPTH)));

endmodule

// File: rtl/cpu_writeback_arbiter.sv
// Writeback stage: NUM_CH result channels, each with a small FIFO, merged
// round-robin onto NUM_WR_PORTS registered register-file write ports.
//   clk, rst_n : clock, asynchronous active-low reset
//   wb         : cpu_writeback_arbiter_if slave (ch_* in, wr_*/pend_mask out)
module cpu_writeback_arbiter
    import cpu_wb_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int NUM_WR_PORTS = 1,
    parameter int FIFO_DEPTH   = 2,
    parameter bit DROP_R0      = 1'b1
) (
    input logic                    clk,
    input logic                    rst_n,
    cpu_writeback_arbiter_if.slave wb
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]              ready;
    logic [NUM_CH-1:0]              push;
    logic [NUM_CH-1:0]              pop;
    wb_entry_t                      head      [NUM_CH];
    logic [CNT_W-1:0]               count     [NUM_CH];
    logic [FIFO_DEPTH-1:0]          ent_valid [NUM_CH];
    wb_entry_t [FIFO_DEPTH-1:0]     ents      [NUM_CH];

    logic [RR_W-1:0]                          rr_ptr;
    logic [RR_W-1:0]                          next_rr;
    logic [NUM_WR_PORTS-1:0]                  g_val;
    logic [NUM_WR_PORTS-1:0][RID_W-1:0]       g_rd;
    logic [NUM_WR_PORTS-1:0][REG_WIDTH-1:0]   g_data;
    logic [NUM_WR_PORTS-1:0]                  wr_en_q;
    logic [NUM_WR_PORTS-1:0][RID_W-1:0]       wr_addr_q;
    logic [NUM_WR_PORTS-1:0][REG_WIDTH-1:0]   wr_data_q;
    logic [NUM_REGS-1:0]                      pend;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        wb_req_t   req;
        wb_entry_t push_entry;

        assign req = '{valid:      wb.ch_valid[c],
                       mem_to_reg: wb.ch_mem_to_reg[c],
                       rd:         wb.ch_rd[c],
                       mem_data:   wb.ch_mem_data[c],
                       alu_data:   wb.ch_alu_data[c]};

        // The data source is resolved here so the FIFO never stores mem_to_reg.
        assign push_entry.rd   = req.rd;
        assign push_entry.data = req.mem_to_reg ? req.mem_data : req.alu_data;

        assign ready[c] = (count[c] < CNT_W'(FIFO_DEPTH));
        // An r0 write still completes its handshake but is never queued.
        assign push[c]  = req.valid && ready[c] && !(DROP_R0 && (req.rd == '0));

        cpu_wb_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .entry_t    (wb_entry_t)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (push[c]),
            .push_entry (push_entry),
            .pop        (pop[c]),
            .head       (head[c]),
            .count      (count[c]),
            .ent_valid  (ent_valid[c]),
            .ents       (ents[c])
        );
    end

    // Round-robin scan starting at rr_ptr. A head whose rd is already granted
    // this cycle stays queued, so two writes to one register keep their order.
    always_comb begin
        int   n;
        int   ch;
        logic hit;
        n       = 0;
        ch      = 0;
        hit     = 1'b0;
        pop     = '0;
        g_val   = '0;
        g_rd    = '0;
        g_data  = '0;
        next_rr = rr_ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            ch = (int'(rr_ptr) + k) % NUM_CH;
            for (int c = 0; c < NUM_CH; c++) begin
                if ((c == ch) && (count[c] != '0) && (n < NUM_WR_PORTS)) begin
                    hit = 1'b0;
                    for (int p = 0; p < NUM_WR_PORTS; p++) begin
                        if (g_val[p] && (g_rd[p] == head[c].rd)) hit = 1'b1;
                    end
                    if (!hit) begin
                        pop[c] = 1'b1;
                        for (int p = 0; p < NUM_WR_PORTS; p++) begin
                            if (p == n) begin
                                g_val[p]  = 1'b1;
                                g_rd[p]   = head[c].rd;
                                g_data[p] = head[c].data;
                            end
                        end
                        n       = n + 1;
                        next_rr = RR_W'((c + 1) % NUM_CH);
                    end
                end
            end
        end
    end

    // Ports without a grant drop wr_en but keep their last address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rr_ptr  <= next_rr;
            wr_en_q <= g_val;
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (g_val[p]) begin
                    wr_addr_q[p] <= g_rd[p];
                    wr_data_q[p] <= g_data[p];
                end
            end
        end
    end

    // A register stays pending until the cycle after its write is presented.
    always_comb begin
        pend = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (ent_valid[c][i]) pend[ents[c][i].rd] = 1'b1;
            end
        end
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (wr_en_q[p]) pend[wr_addr_q[p]] = 1'b1;
        end
    end

    assign wb.ch_ready  = ready;
    assign wb.wr_en     = wr_en_q;
    assign wb.wr_addr   = wr_addr_q;
    assign wb.wr_data   = wr_data_q;
    assign wb.pend_mask = pend;

    for (genvar a = 0; a < NUM_WR_PORTS; a++) begin : g_pa
        for (genvar b = a + 1; b < NUM_WR_PORTS; b++) begin : g_pb
            a_no_dup_addr: assert property (@(posedge clk) disable iff (!rst_n)
                !(wr_en_q[a] && wr_en_q[b] && (wr_addr_q[a] == wr_addr_q[b])));
        end
    end

endmodule

// File: tb/tb_cpu_writeback_arbiter.sv
module tb_cpu_writeback_arbiter;
  import cpu_wb_pkg::*;

  localparam int NCH   = 2;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [RID_W-1:0]     rd;
    logic [REG_WIDTH-1:0] data;
  } ent_t;

  typedef struct {
    int                   cyc;
    int                   port;
    logic [RID_W-1:0]     rd;
    logic [REG_WIDTH-1:0] data;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [NCH-1:0]                s_valid = '0;
  logic [NCH-1:0]                s_m2r = '0;
  logic [NCH-1:0][RID_W-1:0]     s_rd = '0;
  logic [NCH-1:0][REG_WIDTH-1:0] s_mem = '0;
  logic [NCH-1:0][REG_WIDTH-1:0] s_alu = '0;

  // Instance 0: one write port; instance 1: two write ports. Same inputs.
  cpu_writeback_arbiter_if #(.NUM_CH(NCH), .NUM_WR_PORTS(1)) if0 ();
  cpu_writeback_arbiter_if #(.NUM_CH(NCH), .NUM_WR_PORTS(2)) if1 ();

  assign if0.ch_valid = s_valid;  assign if1.ch_valid = s_valid;
  assign if0.ch_mem_to_reg = s_m2r; assign if1.ch_mem_to_reg = s_m2r;
  assign if0.ch_rd = s_rd;        assign if1.ch_rd = s_rd;
  assign if0.ch_mem_data = s_mem; assign if1.ch_mem_data = s_mem;
  assign if0.ch_alu_data = s_alu; assign if1.ch_alu_data = s_alu;

  cpu_writeback_arbiter #(.NUM_CH(NCH), .NUM_WR_PORTS(1), .FIFO_DEPTH(DEPTH), .DROP_R0(1'b1))
    dut0 (.clk(clk), .rst_n(rst_n), .wb(if0));
  cpu_writeback_arbiter #(.NUM_CH(NCH), .NUM_WR_PORTS(2), .FIFO_DEPTH(DEPTH), .DROP_R0(1'b1))
    dut1 (.clk(clk), .rst_n(rst_n), .wb(if1));

  logic [1:0]                o_en    [2];
  logic [1:0][RID_W-1:0]     o_addr  [2];
  logic [1:0][REG_WIDTH-1:0] o_data  [2];
  logic [NCH-1:0]            o_ready [2];
  logic [NUM_REGS-1:0]       o_pend  [2];

  assign o_en[0]    = {1'b0, if0.wr_en};
  assign o_addr[0]  = {{RID_W{1'b0}}, if0.wr_addr};
  assign o_data[0]  = {{REG_WIDTH{1'b0}}, if0.wr_data};
  assign o_ready[0] = if0.ch_ready;
  assign o_pend[0]  = if0.pend_mask;
  assign o_en[1]    = if1.wr_en;
  assign o_addr[1]  = if1.wr_addr;
  assign o_data[1]  = if1.wr_data;
  assign o_ready[1] = if1.ch_ready;
  assign o_pend[1]  = if1.pend_mask;

  // ---------------- scoreboard state ----------------
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp_q [2][$];
  ent_t m_q   [2][NCH][$];
  int   m_rr  [2];
  logic m_en  [2][2];
  logic [RID_W-1:0] m_addr [2][2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      m_rr[i] = 0;
      for (int c = 0; c < NCH; c++) m_q[i][c].delete();
      for (int p = 0; p < 2; p++) begin
        m_en[i][p] = 1'b0;
        m_addr[i][p] = '0;
      end
    end
  endtask

  // One clock edge of the reference: grants come from the queues as they
  // stood before the edge, acceptance from the occupancy before the edge.
  task automatic model_step(input int i);
    int   np, ng, last;
    int   pre [NCH];
    logic used;
    ent_t e;
    logic [RID_W-1:0] granted [$];
    np = i + 1;
    ng = 0;
    last = -1;
    for (int c = 0; c < NCH; c++) pre[c] = m_q[i][c].size();
    for (int p = 0; p < 2; p++) m_en[i][p] = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_rr[i] + k) % NCH;
      if (pre[c] > 0 && ng < np) begin
        used = 1'b0;
        foreach (granted[g]) if (granted[g] == m_q[i][c][0].rd) used = 1'b1;
        if (!used) begin
          e = m_q[i][c].pop_front();
          granted.push_back(e.rd);
          exp_q[i].push_back('{cyc, ng, e.rd, e.data});
          m_en[i][ng] = 1'b1;
          m_addr[i][ng] = e.rd;
          ng++;
          last = c;
        end
      end
    end
    if (last >= 0) m_rr[i] = (last + 1) % NCH;
    for (int c = 0; c < NCH; c++) begin
      if (s_valid[c] && pre[c] < DEPTH && s_rd[c] != '0)
        m_q[i][c].push_back('{s_rd[c], s_m2r[c] ? s_mem[c] : s_alu[c]});
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        logic [NCH-1:0]      er;
        logic [NUM_REGS-1:0] ep;
        er = '0;
        ep = '0;
        for (int c = 0; c < NCH; c++) begin
          er[c] = (m_q[i][c].size() < DEPTH);
          foreach (m_q[i][c][j]) ep[m_q[i][c][j].rd] = 1'b1;
        end
        for (int p = 0; p <= i; p++) if (m_en[i][p]) ep[m_addr[i][p]] = 1'b1;
        chk($sformatf("ch_ready[i%0d]", i), 64'(o_ready[i]), 64'(er));
        chk($sformatf("pend_mask[i%0d]", i), 64'(o_pend[i]), 64'(ep));
        for (int p = 0; p <= i; p++) begin
          logic want;
          exp_t x;
          want = (exp_q[i].size() > 0) && (exp_q[i][0].cyc == cyc) && (exp_q[i][0].port == p);
          chk($sformatf("wr_en[i%0d p%0d]", i, p), 64'(o_en[i][p]), 64'(want));
          if (want) begin
            x = exp_q[i].pop_front();
            if (o_en[i][p]) begin
              chk($sformatf("wr_addr[i%0d p%0d]", i, p), 64'(o_addr[i][p]), 64'(x.rd));
              chk($sformatf("wr_data[i%0d p%0d]", i, p), 64'(o_data[i][p]), 64'(x.data));
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic [RID_W-1:0] rd, input logic [REG_WIDTH-1:0] alu,
                       input logic [REG_WIDTH-1:0] mem, input logic m2r);
    s_valid[c] = 1'b1;
    s_rd[c]    = rd;
    s_alu[c]   = alu;
    s_mem[c]   = mem;
    s_m2r[c]   = m2r;
  endtask

  task automatic idle();
    s_valid = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("reset wr_en i0", 64'(o_en[0]), 64'd0);
    chk("reset ready i0", 64'(o_ready[0]), 64'd3);
    chk("reset pend i1", 64'(o_pend[1]), 64'd0);

    // single push: ch0 rd=5 alu=0x1234
    tick(); drive(0, 5, 32'h1234, 32'hDEAD, 1'b0);
    tick(); idle();
    @(negedge clk);
    chk("single pend5 queued", 64'(o_pend[0][5]), 64'd1);
    chk("single no early write", 64'(o_en[0][0]), 64'd0);
    @(negedge clk);
    chk("single wr_en", 64'(o_en[0][0]), 64'd1);
    chk("single wr_addr", 64'(o_addr[0][0]), 64'd5);
    chk("single wr_data", 64'(o_data[0][0]), 64'h1234);
    chk("single pend5 writing", 64'(o_pend[0][5]), 64'd1);
    @(negedge clk);
    chk("single pend5 clear", 64'(o_pend[0][5]), 64'd0);

    // reset with two entries queued
    tick(); drive(0, 10, 32'hA0A0, 32'h0, 1'b0); drive(1, 11, 32'hB1B1, 32'h0, 1'b0);
    tick(); idle();
    rst_n = 1'b0;
    clear_model();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midreset wr_en i%0d", i), 64'(o_en[i]), 64'd0);
      chk($sformatf("midreset pend i%0d", i), 64'(o_pend[i]), 64'd0);
      chk($sformatf("midreset ready i%0d", i), 64'(o_ready[i]), 64'd3);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) tick();

    // contention: 3/7 tie, then 4/8 tie
    drive(0, 3, 32'h3333, 32'h0, 1'b0); drive(1, 7, 32'h7777, 32'h0, 1'b0);
    tick(); idle(); repeat (3) tick();
    drive(0, 4, 32'h4444, 32'h0, 1'b0); drive(1, 8, 32'h8888, 32'h0, 1'b0);
    tick(); idle(); repeat (3) tick();

    // same rd on both heads, ch1 selects mem data
    drive(0, 9, 32'h9000, 32'h0, 1'b0); drive(1, 9, 32'h0, 32'h9111, 1'b1);
    tick(); idle(); repeat (3) tick();

    // ch0 always valid, ch1 valid for 4 cycles
    for (int k = 0; k < 6; k++) begin
      drive(0, RID_W'($urandom_range(1, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (k < 4) drive(1, RID_W'(12 + k), 32'hC000 + k, $urandom, 1'b0);
      else s_valid[1] = 1'b0;
      tick();
    end
    idle(); repeat (12) tick();

    // r0 write is swallowed
    drive(0, 0, 32'hFFFF, 32'h0, 1'b0);
    tick(); idle();
    @(negedge clk);
    chk("r0 pend0 i0", 64'(o_pend[0][0]), 64'd0);
    chk("r0 ready i0", 64'(o_ready[0]), 64'd3);
    @(negedge clk);
    chk("r0 no write i0", 64'(o_en[0]), 64'd0);
    chk("r0 no write i1", 64'(o_en[1]), 64'd0);

    // randomized traffic
    repeat (400) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        s_valid[c] = 1'($urandom_range(0, 1));
        s_rd[c]    = RID_W'($urandom_range(0, 7));
        s_alu[c]   = $urandom;
        s_mem[c]   = $urandom;
        s_m2r[c]   = 1'($urandom_range(0, 1));
      end
    end
    tick(); idle();
    repeat (12) tick();
    @(negedge clk);
    chk("leftover expected i0", 64'(exp_q[0].size()), 64'd0);
    chk("leftover expected i1", 64'(exp_q[1].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
